controle_reservatorio: RTL

- Sequential tank controller directly upstream of the irrigation-mode decoder.
- Drives the inlet valve.
- Produces the registered Esvaziar, Nivel_cheio, Limpeza and Parada_Rega flags that the decoder combines with REGA_Mode to select sprinkler, drip or error.
- Runs the fill -> full-hold -> drain cycle, periodic cleaning, operator pause and sensor-fault lockout.

---
 rtl/controle_reservatorio.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/controle_reservatorio.sv
// ----------------------------------------------------------------------------
// controle_reservatorio
//   Tank controller in front of the irrigation-mode decoder. Runs the
//   fill -> full-hold -> drain cycle, periodic and manual cleaning, operator
//   pause while draining, and a sticky sensor-fault lockout.
//
//   Optional feature: define CONTROLE_RESERVATORIO_TIMEOUT_EN to add a fill
//   watchdog (ENCHENDO lasting TIMEOUT_CYCLES cycles -> FALHA).
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   Inicio          start request (level, sampled in IDLE, synchronous)
//   Sensor_baixo    1 = water above low probe (asynchronous)
//   Sensor_alto     1 = water at/above high probe (asynchronous)
//   Pedido_limpeza  one-cycle manual cleaning request (synchronous)
//   Parada          operator pause, level (asynchronous)
//   Valvula_entrada inlet valve open            (registered)
//   Esvaziar        tank draining               (registered)
//   Nivel_cheio     tank full, holding          (registered)
//   Limpeza         cleaning phase active       (registered)
//   Parada_Rega     irrigation paused           (registered)
//   Falha           sensor fault / fill timeout (registered, sticky)
// ----------------------------------------------------------------------------
module controle_reservatorio #(
    parameter int unsigned HOLD_CYCLES        = 16,
    parameter int unsigned LIMPEZA_CYCLES     = 32,
    parameter int unsigned CICLOS_ATE_LIMPEZA = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 1024,
    parameter int unsigned CNT_W              = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic Inicio,
    input  logic Sensor_baixo,
    input  logic Sensor_alto,
    input  logic Pedido_limpeza,
    input  logic Parada,
    output logic Valvula_entrada,
    output logic Esvaziar,
    output logic Nivel_cheio,
    output logic Limpeza,
    output logic Parada_Rega,
    output logic Falha
);

    localparam int unsigned DRAIN_W = $clog2(CICLOS_ATE_LIMPEZA + 1);
    localparam int unsigned MAX_HL  = (HOLD_CYCLES > LIMPEZA_CYCLES) ? HOLD_CYCLES : LIMPEZA_CYCLES;
    // Saturation point of the phase counter: the largest limit it ever compares against.
    localparam int unsigned MAX_ALL = (MAX_HL > TIMEOUT_CYCLES) ? MAX_HL : TIMEOUT_CYCLES;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ENCHENDO   = 3'd1,
        ST_CHEIO      = 3'd2,
        ST_ESVAZIANDO = 3'd3,
        ST_LIMPEZA    = 3'd4,
        ST_FALHA      = 3'd5
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [CNT_W-1:0]     phase_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [DRAIN_W-1:0]   drain_inc;
    logic                 limpeza_pend;
    logic                 cnt_run;
    logic                 limp_exit;
    logic                 drain_step;

    // Two-flop synchronisers for the asynchronous level inputs.
    logic [1:0] sb_q;
    logic [1:0] sa_q;
    logic [1:0] pa_q;
    logic       sb_s;
    logic       sa_s;
    logic       pa_s;
    logic       sensor_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= 2'b00;
            sa_q <= 2'b00;
            pa_q <= 2'b00;
        end else begin
            sb_q <= {sb_q[0], Sensor_baixo};
            sa_q <= {sa_q[0], Sensor_alto};
            pa_q <= {pa_q[0], Parada};
        end
    end

    assign sb_s = sb_q[1];
    assign sa_s = sa_q[1];
    assign pa_s = pa_q[1];

    // High probe wet while low probe dry is physically impossible.
    assign sensor_fault = sa_s & ~sb_s;

    // Drain-cycle count after the current drain completes, saturating.
    assign drain_inc = (drain_cnt == DRAIN_W'(CICLOS_ATE_LIMPEZA)) ? drain_cnt
                                                                   : drain_cnt + DRAIN_W'(1);

    // Next-state logic: sensor fault > timeout > normal transition.
    always_comb begin
        state_nx = state;
        cnt_run  = 1'b0;

        if (sensor_fault) begin
            state_nx = ST_FALHA;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Inicio) begin
                        state_nx = sa_s ? ST_CHEIO : ST_ENCHENDO;
                    end
                end
                ST_ENCHENDO: begin
`ifdef CONTROLE_RESERVATORIO_TIMEOUT_EN
                    cnt_run = 1'b1;
                    if (sa_s) begin
                        state_nx = ST_CHEIO;
                    end else if (phase_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nx = ST_FALHA;
                    end
`else
                    if (sa_s) begin
                        state_nx = ST_CHEIO;
                    end
`endif
                end
                ST_CHEIO: begin
                    cnt_run = 1'b1;
                    if (phase_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        state_nx = ST_ESVAZIANDO;
                    end
                end
                ST_ESVAZIANDO: begin
                    if (!sb_s) begin
                        if (limpeza_pend || (drain_inc == DRAIN_W'(CICLOS_ATE_LIMPEZA))) begin
                            state_nx = ST_LIMPEZA;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end
                end
                ST_LIMPEZA: begin
                    cnt_run = 1'b1;
                    if (phase_cnt == CNT_W'(LIMPEZA_CYCLES - 1)) begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_FALHA: begin
                    state_nx = ST_FALHA;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    assign limp_exit  = (state == ST_LIMPEZA) && (state_nx == ST_IDLE);
    assign drain_step = (state == ST_ESVAZIANDO) &&
                        ((state_nx == ST_IDLE) || (state_nx == ST_LIMPEZA));

    // State, counters and Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            phase_cnt       <= '0;
            drain_cnt       <= '0;
            limpeza_pend    <= 1'b0;
            Valvula_entrada <= 1'b0;
            Esvaziar        <= 1'b0;
            Nivel_cheio     <= 1'b0;
            Limpeza         <= 1'b0;
            Parada_Rega     <= 1'b0;
            Falha           <= 1'b0;
        end else begin
            state <= state_nx;

            if (state_nx != state) begin
                phase_cnt <= '0;
            end else if (cnt_run && (phase_cnt != CNT_W'(MAX_ALL - 1))) begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end

            if (limp_exit) begin
                drain_cnt <= '0;
            end else if (drain_step) begin
                drain_cnt <= drain_inc;
            end

            // Exit clear wins over a request in the same cycle.
            if (limp_exit) begin
                limpeza_pend <= 1'b0;
            end else if (Pedido_limpeza) begin
                limpeza_pend <= 1'b1;
            end

            Valvula_entrada <= (state_nx == ST_ENCHENDO) || (state_nx == ST_LIMPEZA);
            Esvaziar        <= (state_nx == ST_ESVAZIANDO);
            Nivel_cheio     <= (state_nx == ST_CHEIO);
            Limpeza         <= (state_nx == ST_LIMPEZA);
            Parada_Rega     <= (state_nx == ST_ESVAZIANDO) && pa_s;
            Falha           <= (state_nx == ST_FALHA);
        end
    end

endmodule
